// File: rtl/control_pkg.sv
// Shared control definitions: opcodes, ALUOp classes and control-vector bit positions.
package control_pkg;

  localparam int unsigned NUM_SIGNALS = 8;

  // Opcode field instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation classes consumed by the ALU-control block
  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_RTYP = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;
  localparam logic [2:0] ALUOP_OR   = 3'b100;
  localparam logic [2:0] ALUOP_SLT  = 3'b101;
  localparam logic [2:0] ALUOP_SLTU = 3'b110;
  localparam logic [2:0] ALUOP_LUI  = 3'b111;

  // Positions within the MSB-first control vector [0:NUM_SIGNALS-1]
  localparam int unsigned IDX_REGDST   = 0;
  localparam int unsigned IDX_BRANCH   = 1;
  localparam int unsigned IDX_MEMREAD  = 2;
  localparam int unsigned IDX_MEMTOREG = 3;
  localparam int unsigned IDX_MEMWRITE = 4;
  localparam int unsigned IDX_ALUSRC   = 5;
  localparam int unsigned IDX_REGWRITE = 6;
  localparam int unsigned IDX_SIGNEXT  = 7;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: opcode -> control vector and ALU class.
module control_decode
  import control_pkg::*;
(
  input  logic [5:0]             ins,
  output logic [0:NUM_SIGNALS-1] signals,
  output logic [2:0]             alu_op
);

  // Full-case table; unlisted opcodes fall to a safe NOP with no write or memory access
  always_comb begin
    signals = '0;
    alu_op  = ALUOP_ADD;
    case (ins)
      OP_RTYPE: begin
        signals = 8'b1000_0010;
        alu_op  = ALUOP_RTYP;
      end
      OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU: begin
        signals = 8'b0011_0111;
        alu_op  = ALUOP_ADD;
      end
      OP_SW, OP_SB, OP_SH: begin
        signals = 8'b0000_1101;
        alu_op  = ALUOP_ADD;
      end
      OP_BEQ, OP_BNE: begin
        signals = 8'b0100_0001;
        alu_op  = ALUOP_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        signals = 8'b0000_0111;
        alu_op  = ALUOP_ADD;
      end
      OP_ANDI: begin
        signals = 8'b0000_0110;
        alu_op  = ALUOP_AND;
      end
      OP_ORI: begin
        signals = 8'b0000_0110;
        alu_op  = ALUOP_OR;
      end
      OP_SLTI: begin
        signals = 8'b0000_0111;
        alu_op  = ALUOP_SLT;
      end
      OP_SLTIU: begin
        signals = 8'b0000_0111;
        alu_op  = ALUOP_SLTU;
      end
      OP_LUI: begin
        signals = 8'b0000_0110;
        alu_op  = ALUOP_LUI;
      end
      // j/jal and everything else: all strobes low
      default: begin
        signals = '0;
        alu_op  = ALUOP_ADD;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder with a one-cycle registered output stage and synchronous reset.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned num_signals = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             ins,
  output logic [0:num_signals-1] signals,
  output logic [2:0]             ALUOp
);

  logic [0:NUM_SIGNALS-1] dec_signals;
  logic [2:0]             dec_alu_op;

  control_decode u_decode (
    .ins     (ins),
    .signals (dec_signals),
    .alu_op  (dec_alu_op)
  );

  // Register the decode; reset wins over any opcode presented at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      signals <= '0;
      ALUOp   <= ALUOP_ADD;
    end else begin
      signals <= dec_signals;
      ALUOp   <= dec_alu_op;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed cases plus randomized opcodes against a rule-based model.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] ins;
  logic [0:7] signals;
  logic [2:0] ALUOp;

  int n_checks;
  int n_fail;

  control_unit #(.num_signals(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ins     (ins),
    .signals (signals),
    .ALUOp   (ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got signals=%b aluop=%b, expected signals=%b aluop=%b",
               tag, got[10:3], got[2:0], exp[10:3], exp[2:0]);
    end
  endtask

  // Reference built from instruction classes: each strobe is a boolean of the class set
  function automatic logic [10:0] model(input logic [5:0] op);
    logic is_r, is_load, is_store, is_br, is_arith_imm, is_logic_imm;
    logic [7:0] s;
    logic [2:0] a;
    is_r         = (op == 6'd0);
    is_load      = op inside {6'b100011, 6'b100000, 6'b100001, 6'b100100, 6'b100101};
    is_store     = op inside {6'b101011, 6'b101000, 6'b101001};
    is_br        = op inside {6'b000100, 6'b000101};
    is_arith_imm = op inside {6'b001000, 6'b001001, 6'b001010, 6'b001011};
    is_logic_imm = op inside {6'b001100, 6'b001101, 6'b001111};
    // s[7] is RegDst ... s[0] is SignExt (written MSB-first like the table)
    s[7] = is_r;
    s[6] = is_br;
    s[5] = is_load;
    s[4] = is_load;
    s[3] = is_store;
    s[2] = is_load | is_store | is_arith_imm | is_logic_imm;
    s[1] = is_r | is_load | is_arith_imm | is_logic_imm;
    s[0] = is_load | is_store | is_br | is_arith_imm;
    case (op)
      6'b000000: a = 3'd2;
      6'b000100, 6'b000101: a = 3'd1;
      6'b001100: a = 3'd3;
      6'b001101: a = 3'd4;
      6'b001010: a = 3'd5;
      6'b001011: a = 3'd6;
      6'b001111: a = 3'd7;
      default:   a = 3'd0;
    endcase
    return {s, a};
  endfunction

  // Apply one edge's inputs, then compare the registered result just after the edge
  task automatic step(input string tag, input logic r, input logic [5:0] op);
    logic [10:0] exp;
    rst = r;
    ins = op;
    exp = r ? 11'd0 : model(op);
    @(posedge clk);
    #1;
    check(tag, {signals, ALUOp}, exp);
  endtask

  // Also pin a few table rows with literal values independent of the model
  task automatic step_lit(input string tag, input logic [5:0] op, input logic [10:0] exp);
    rst = 1'b0;
    ins = op;
    @(posedge clk);
    #1;
    check(tag, {signals, ALUOp}, exp);
  endtask

  logic [5:0] defined_ops [20];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    defined_ops = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o05, 6'o10, 6'o11, 6'o12, 6'o13, 6'o14,
                    6'o15, 6'o17, 6'o40, 6'o41, 6'o43, 6'o44, 6'o45, 6'o50, 6'o51, 6'o53};
    rst = 1'b1;
    ins = 6'b000000;
    @(negedge clk);

    step("reset0", 1'b1, 6'b000000);
    step("reset1", 1'b1, 6'b000000);

    step_lit("rtype", 6'b000000, {8'b1000_0010, 3'b010});
    step_lit("lw",    6'b100011, {8'b0011_0111, 3'b000});
    step_lit("sw",    6'b101011, {8'b0000_1101, 3'b000});
    step_lit("beq",   6'b000100, {8'b0100_0001, 3'b001});
    step_lit("lui",   6'b001111, {8'b0000_0110, 3'b111});
    step_lit("andi",  6'b001100, {8'b0000_0110, 3'b011});
    step_lit("ori",   6'b001101, {8'b0000_0110, 3'b100});
    step_lit("slti",  6'b001010, {8'b0000_0111, 3'b101});
    step_lit("sltiu", 6'b001011, {8'b0000_0111, 3'b110});
    step_lit("j",     6'b000010, {8'b0000_0000, 3'b000});
    step_lit("undef", 6'b100111, {8'b0000_0000, 3'b000});
    step_lit("lbu",   6'b100100, {8'b0011_0111, 3'b000});

    // Reset over a steady load opcode, then release
    step("rst_mid", 1'b1, 6'b100011);
    step_lit("rst_release", 6'b100011, {8'b0011_0111, 3'b000});

    // Every opcode once through the model
    for (int i = 0; i < 64; i++) step("sweep", 1'b0, 6'(i));

    // Random mix: half from the defined set, occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      logic       r;
      if ($urandom_range(0, 1) == 0) op = defined_ops[$urandom_range(0, 19)];
      else op = 6'($urandom_range(0, 63));
      r = ($urandom_range(0, 9) == 0);
      step("random", r, op);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
